// File: rtl/seg7_onchip_memory_arbiter_if.sv
// seg7_onchip_memory_arbiter_if: Avalon-MM signals of both requesters and the shared RAM port
interface seg7_onchip_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   a_address, b_address;
  logic                    a_read, a_write, b_read, b_write;
  logic [DATA_WIDTH-1:0]   a_writedata, b_writedata;
  logic [DATA_WIDTH/8-1:0] a_byteenable, b_byteenable;
  logic                    a_waitrequest, b_waitrequest;
  logic [DATA_WIDTH-1:0]   a_readdata, b_readdata;
  logic                    a_readdatavalid, b_readdatavalid;
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH/8-1:0] mem_byteenable;
  logic                    mem_chipselect, mem_write, mem_clken;
  logic [DATA_WIDTH-1:0]   mem_writedata, mem_readdata;
  modport slave (
    input  a_address, a_read, a_write, a_writedata, a_byteenable,
    input  b_address, b_read, b_write, b_writedata, b_byteenable,
    input  mem_readdata,
    output a_waitrequest, a_readdata, a_readdatavalid,
    output b_waitrequest, b_readdata, b_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
  modport master (
    output a_address, a_read, a_write, a_writedata, a_byteenable,
    output b_address, b_read, b_write, b_writedata, b_byteenable,
    output mem_readdata,
    input  a_waitrequest, a_readdata, a_readdatavalid,
    input  b_waitrequest, b_readdata, b_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/seg7_onchip_memory_arbiter.sv
// seg7_onchip_memory_arbiter: two-port round-robin / fixed-priority arbiter in front of a 1-cycle-latency RAM
module seg7_onchip_memory_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input logic clk,
  input logic reset_n,
  seg7_onchip_memory_arbiter_if.slave bus
);
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;
  logic                    w_a_req, w_b_req, w_gnt_a, w_gnt_b, w_gnt;
  logic                    w_win_read, w_win_write;
  logic [ADDR_WIDTH-1:0]   w_address;
  logic [DATA_WIDTH/8-1:0] w_byteenable;
  logic [DATA_WIDTH-1:0]   w_writedata;
  logic                    r_last_grant, r_rd_pend, r_rd_port;
  // Grant decision; nothing is granted while reset is held
  always_comb begin
    w_a_req = reset_n & (bus.a_read | bus.a_write);
    w_b_req = reset_n & (bus.b_read | bus.b_write);
    w_gnt_a = w_a_req & (!w_b_req | (FIXED_PRIORITY != 0) | (r_last_grant == GRANT_B));
    w_gnt_b = w_b_req & !w_gnt_a;
    w_gnt   = w_gnt_a | w_gnt_b;
  end
  // Winner's fields onto the RAM port (A's when idle) and per-port handshake/return
  always_comb begin
    w_address             = w_gnt_b ? bus.b_address : bus.a_address;
    w_byteenable          = w_gnt_b ? bus.b_byteenable : bus.a_byteenable;
    w_writedata           = w_gnt_b ? bus.b_writedata : bus.a_writedata;
    w_win_write           = w_gnt_b ? bus.b_write : bus.a_write;
    w_win_read            = w_gnt_b ? bus.b_read : bus.a_read;
    bus.mem_address       = w_address;
    bus.mem_byteenable    = w_byteenable;
    bus.mem_writedata     = w_writedata;
    bus.mem_write         = w_gnt & w_win_write;
    bus.mem_chipselect    = w_gnt;
    bus.mem_clken         = 1'b1;
    bus.a_waitrequest     = !reset_n | (w_a_req & !w_gnt_a);
    bus.b_waitrequest     = !reset_n | (w_b_req & !w_gnt_b);
    bus.a_readdata        = bus.mem_readdata;
    bus.b_readdata        = bus.mem_readdata;
    bus.a_readdatavalid   = r_rd_pend & (r_rd_port == GRANT_A);
    bus.b_readdatavalid   = r_rd_pend & (r_rd_port == GRANT_B);
  end
  // Round-robin history and one-deep read-return tracking (a read+write collision returns nothing)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= GRANT_B;
      r_rd_pend    <= 1'b0;
      r_rd_port    <= GRANT_A;
    end else begin
      if (w_gnt) r_last_grant <= w_gnt_b;
      r_rd_pend <= w_gnt & w_win_read & !w_win_write;
      r_rd_port <= w_gnt_b;
    end
  end
endmodule

// File: tb/tb_seg7_onchip_memory_arbiter.sv
// tb_seg7_onchip_memory_arbiter: round-robin and fixed-priority arbiters driven in lockstep against a RAM model
module tb_seg7_onchip_memory_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0, init = 1'b0;
  logic [9:0]  a_addr, b_addr;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [31:0] a_wd, b_wd;
  logic [3:0]  a_be, b_be;
  logic        a_wait [2], b_wait [2], a_rdv [2], b_rdv [2], cs [2], mwr [2], clken [2];
  logic [31:0] a_rdata [2], b_rdata [2];
  logic [31:0] ref_mem [2][1024];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : env
    seg7_onchip_memory_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();
    logic [31:0] ram [1024];
    logic [31:0] q;
    seg7_onchip_memory_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .FIXED_PRIORITY(g)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));
    assign bus.a_address = a_addr;
    assign bus.a_read = a_rd;
    assign bus.a_write = a_wr;
    assign bus.a_writedata = a_wd;
    assign bus.a_byteenable = a_be;
    assign bus.b_address = b_addr;
    assign bus.b_read = b_rd;
    assign bus.b_write = b_wr;
    assign bus.b_writedata = b_wd;
    assign bus.b_byteenable = b_be;
    assign bus.mem_readdata = q;
    assign a_wait[g] = bus.a_waitrequest;
    assign b_wait[g] = bus.b_waitrequest;
    assign a_rdv[g] = bus.a_readdatavalid;
    assign b_rdv[g] = bus.b_readdatavalid;
    assign a_rdata[g] = bus.a_readdata;
    assign b_rdata[g] = bus.b_readdata;
    assign cs[g] = bus.mem_chipselect;
    assign mwr[g] = bus.mem_write;
    assign clken[g] = bus.mem_clken;
    always @(posedge clk) begin
      if (init) begin
        for (int i = 0; i < 1024; i++) ram[i] <= 32'h5A5A0000 | i;
      end else if (bus.mem_chipselect) begin
        q <= ram[bus.mem_address];
        if (bus.mem_write)
          for (int k = 0; k < 4; k++)
            if (bus.mem_byteenable[k]) ram[bus.mem_address][8*k +: 8] <= bus.mem_writedata[8*k +: 8];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
  endtask

  task automatic pulse_reset();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    a_addr = '0; b_addr = '0; a_wd = '0; b_wd = '0; a_be = 4'hF; b_be = 4'hF;
    init = 1'b1;
    reset_n = 1'b0;
    a_rd = 1'b1; b_rd = 1'b1;
    step();
    init = 1'b0;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_wait[e] !== 1'b1) begin errors++; $display("FAIL reset_a_wait env%0d got %b exp 1", e, a_wait[e]); end
      checks++; if (b_wait[e] !== 1'b1) begin errors++; $display("FAIL reset_b_wait env%0d got %b exp 1", e, b_wait[e]); end
      checks++; if (cs[e] !== 1'b0) begin errors++; $display("FAIL reset_cs env%0d got %b exp 0", e, cs[e]); end
      checks++; if (mwr[e] !== 1'b0) begin errors++; $display("FAIL reset_write env%0d got %b exp 0", e, mwr[e]); end
      checks++; if ({a_rdv[e], b_rdv[e]} !== 2'b00) begin errors++; $display("FAIL reset_rdv env%0d got %b%b exp 00", e, a_rdv[e], b_rdv[e]); end
      checks++; if (clken[e] !== 1'b1) begin errors++; $display("FAIL clken env%0d got %b exp 1", e, clken[e]); end
    end
    step();
    idle();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    a_rd = 1'b1; a_addr = 10'h005;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_wait[e] !== 1'b0) begin errors++; $display("FAIL sr_a_wait env%0d got %b exp 0", e, a_wait[e]); end
      checks++; if (b_wait[e] !== 1'b0) begin errors++; $display("FAIL sr_b_idle_wait env%0d got %b exp 0", e, b_wait[e]); end
      checks++; if (cs[e] !== 1'b1 || mwr[e] !== 1'b0) begin errors++; $display("FAIL sr_cs_write env%0d got %b%b exp 10", e, cs[e], mwr[e]); end
    end
    step();
    idle();
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_rdv[e] !== 1'b1) begin errors++; $display("FAIL sr_a_rdv env%0d got %b exp 1", e, a_rdv[e]); end
      checks++; if (a_rdata[e] !== 32'h5A5A0005) begin errors++; $display("FAIL sr_a_rdata env%0d got %h exp 5a5a0005", e, a_rdata[e]); end
      checks++; if (b_rdv[e] !== 1'b0) begin errors++; $display("FAIL sr_b_rdv env%0d got %b exp 0", e, b_rdv[e]); end
    end
    step();
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_rdv[e] !== 1'b0) begin errors++; $display("FAIL sr_rdv_pulse env%0d got %b exp 0", e, a_rdv[e]); end
    end
    step();
  endtask

  task automatic test_byte_write();
    b_wr = 1'b1; b_addr = 10'h3FF; b_wd = 32'hFFFFFFFF; b_be = 4'hF;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (b_wait[e] !== 1'b0 || cs[e] !== 1'b1 || mwr[e] !== 1'b1) begin errors++; $display("FAIL bw_fill env%0d got wait=%b cs=%b wr=%b exp 0 1 1", e, b_wait[e], cs[e], mwr[e]); end
    end
    step();
    b_wd = 32'h11223344; b_be = 4'h4;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (b_wait[e] !== 1'b0 || cs[e] !== 1'b1 || mwr[e] !== 1'b1) begin errors++; $display("FAIL bw_lane env%0d got wait=%b cs=%b wr=%b exp 0 1 1", e, b_wait[e], cs[e], mwr[e]); end
    end
    step();
    idle();
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (cs[e] !== 1'b0 || mwr[e] !== 1'b0) begin errors++; $display("FAIL bw_after env%0d got cs=%b wr=%b exp 0 0", e, cs[e], mwr[e]); end
      checks++; if (b_rdv[e] !== 1'b0) begin errors++; $display("FAIL bw_no_rdv env%0d got %b exp 0", e, b_rdv[e]); end
    end
    step();
    a_rd = 1'b1; a_addr = 10'h3FF;
    step();
    idle();
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_rdv[e] !== 1'b1 || a_rdata[e] !== 32'hFF22FFFF) begin errors++; $display("FAIL bw_readback env%0d got rdv=%b data=%h exp 1 ff22ffff", e, a_rdv[e], a_rdata[e]); end
    end
    step();
  endtask

  task automatic test_conflict();
    pulse_reset();
    a_addr = 10'h020; b_addr = 10'h030; a_rd = 1'b1; b_rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic odd;
      odd = (i % 2) == 1;
      @(negedge clk);
      checks++; if (a_wait[0] !== odd || b_wait[0] !== !odd) begin errors++; $display("FAIL rr_wait cyc%0d got a=%b b=%b exp a=%b b=%b", i, a_wait[0], b_wait[0], odd, !odd); end
      checks++; if (a_wait[1] !== 1'b0 || b_wait[1] !== 1'b1) begin errors++; $display("FAIL fp_wait cyc%0d got a=%b b=%b exp a=0 b=1", i, a_wait[1], b_wait[1]); end
      if (i > 0) begin
        checks++; if (a_rdv[0] !== odd || b_rdv[0] !== !odd) begin errors++; $display("FAIL rr_rdv cyc%0d got a=%b b=%b exp a=%b b=%b", i, a_rdv[0], b_rdv[0], odd, !odd); end
        checks++; if ((odd ? a_rdata[0] : b_rdata[0]) !== (odd ? 32'h5A5A0020 : 32'h5A5A0030)) begin errors++; $display("FAIL rr_rdata cyc%0d got %h exp %h", i, odd ? a_rdata[0] : b_rdata[0], odd ? 32'h5A5A0020 : 32'h5A5A0030); end
        checks++; if (a_rdv[1] !== 1'b1 || b_rdv[1] !== 1'b0 || a_rdata[1] !== 32'h5A5A0020) begin errors++; $display("FAIL fp_rdv cyc%0d got a=%b b=%b data=%h exp 1 0 5a5a0020", i, a_rdv[1], b_rdv[1], a_rdata[1]); end
      end
      step();
    end
    a_rd = 1'b0;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (b_wait[e] !== 1'b0 || cs[e] !== 1'b1) begin errors++; $display("FAIL b_after_a env%0d got wait=%b cs=%b exp 0 1", e, b_wait[e], cs[e]); end
    end
    checks++; if (b_rdv[0] !== 1'b1 || a_rdv[1] !== 1'b1) begin errors++; $display("FAIL tail_rdv got rr_b=%b fp_a=%b exp 1 1", b_rdv[0], a_rdv[1]); end
    step();
    idle();
    @(negedge clk);
    checks++; if (b_rdv[1] !== 1'b1 || b_rdata[1] !== 32'h5A5A0030) begin errors++; $display("FAIL fp_b_return got rdv=%b data=%h exp 1 5a5a0030", b_rdv[1], b_rdata[1]); end
    step();
  endtask

  task automatic test_reset_mid_read();
    a_rd = 1'b1; a_addr = 10'h005;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_wait[e] !== 1'b0) begin errors++; $display("FAIL rm_grant env%0d got %b exp 0", e, a_wait[e]); end
    end
    step();
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_rdv[e] !== 1'b0) begin errors++; $display("FAIL rm_dropped env%0d got %b exp 0", e, a_rdv[e]); end
    end
    step();
    reset_n = 1'b1;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_rdv[e] !== 1'b0) begin errors++; $display("FAIL rm_after env%0d got %b exp 0", e, a_rdv[e]); end
    end
    step();
    a_rd = 1'b1; b_rd = 1'b1; a_addr = 10'h005; b_addr = 10'h006;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_wait[e] !== 1'b0 || b_wait[e] !== 1'b1) begin errors++; $display("FAIL rm_first_a env%0d got a=%b b=%b exp 0 1", e, a_wait[e], b_wait[e]); end
    end
    step();
    idle();
    step();
  endtask

  task automatic test_read_write_both();
    a_rd = 1'b1; a_wr = 1'b1; a_addr = 10'h010; a_wd = 32'hDEADBEEF; a_be = 4'hF;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_wait[e] !== 1'b0 || cs[e] !== 1'b1 || mwr[e] !== 1'b1) begin errors++; $display("FAIL rw_write env%0d got wait=%b cs=%b wr=%b exp 0 1 1", e, a_wait[e], cs[e], mwr[e]); end
    end
    step();
    idle();
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_rdv[e] !== 1'b0 || b_rdv[e] !== 1'b0) begin errors++; $display("FAIL rw_no_rdv env%0d got a=%b b=%b exp 0 0", e, a_rdv[e], b_rdv[e]); end
    end
    step();
    a_rd = 1'b1;
    step();
    idle();
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      checks++; if (a_rdv[e] !== 1'b1 || a_rdata[e] !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_readback env%0d got rdv=%b data=%h exp 1 deadbeef", e, a_rdv[e], a_rdata[e]); end
    end
    step();
  endtask

  // Reference: last winner per arbiter, a one-entry expected-return slot, and a shadow RAM
  task automatic test_random();
    logic        last_b [2];
    logic        pend [2], pport [2];
    logic [31:0] pdata [2];
    pulse_reset();
    for (int e = 0; e < 2; e++) begin
      last_b[e] = 1'b1; pend[e] = 1'b0; pport[e] = 1'b0; pdata[e] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      logic        n_pend [2], n_port [2];
      logic [31:0] n_data [2];
      a_rd = ($urandom % 3) == 0; a_wr = ($urandom % 4) == 0;
      b_rd = ($urandom % 3) == 0; b_wr = ($urandom % 4) == 0;
      a_addr = 10'h100 + 10'($urandom % 256); b_addr = 10'h100 + 10'($urandom % 256);
      a_wd = $urandom; b_wd = $urandom; a_be = 4'($urandom); b_be = 4'($urandom);
      @(negedge clk);
      for (int e = 0; e < 2; e++) begin
        logic ar, br, win_b, gr, wr;
        logic [9:0] ad;
        ar = a_rd | a_wr;
        br = b_rd | b_wr;
        win_b = (ar && br) ? (e == 0 && !last_b[e]) : br;
        gr = ar | br;
        wr = gr && (win_b ? b_wr : a_wr);
        checks++; if (a_wait[e] !== (ar && win_b) || b_wait[e] !== (br && !win_b)) begin errors++; $display("FAIL rnd_wait env%0d cyc%0d got a=%b b=%b exp a=%b b=%b", e, n, a_wait[e], b_wait[e], ar && win_b, br && !win_b); end
        checks++; if (cs[e] !== gr || mwr[e] !== wr) begin errors++; $display("FAIL rnd_mem env%0d cyc%0d got cs=%b wr=%b exp %b %b", e, n, cs[e], mwr[e], gr, wr); end
        checks++; if (a_rdv[e] !== (pend[e] && !pport[e]) || b_rdv[e] !== (pend[e] && pport[e])) begin errors++; $display("FAIL rnd_rdv env%0d cyc%0d got a=%b b=%b exp a=%b b=%b", e, n, a_rdv[e], b_rdv[e], pend[e] && !pport[e], pend[e] && pport[e]); end
        if (pend[e]) begin
          checks++; if ((pport[e] ? b_rdata[e] : a_rdata[e]) !== pdata[e]) begin errors++; $display("FAIL rnd_rdata env%0d cyc%0d got %h exp %h", e, n, pport[e] ? b_rdata[e] : a_rdata[e], pdata[e]); end
        end
        ad = win_b ? b_addr : a_addr;
        n_pend[e] = gr && !wr && (win_b ? b_rd : a_rd);
        n_port[e] = win_b;
        n_data[e] = ref_mem[e][ad];
        if (wr)
          for (int k = 0; k < 4; k++)
            if ((win_b ? b_be[k] : a_be[k])) ref_mem[e][ad][8*k +: 8] = win_b ? b_wd[8*k +: 8] : a_wd[8*k +: 8];
        if (gr) last_b[e] = win_b;
      end
      step();
      for (int e = 0; e < 2; e++) begin
        pend[e] = n_pend[e]; pport[e] = n_port[e]; pdata[e] = n_data[e];
      end
    end
    idle();
    step();
  endtask

  initial begin
    for (int e = 0; e < 2; e++)
      for (int i = 0; i < 1024; i++) ref_mem[e][i] = 32'h5A5A0000 | i;
    test_reset();
    test_single_read();
    test_byte_write();
    test_conflict();
    test_reset_mid_read();
    test_read_write_both();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
